// File: rtl/ram_arbiter.sv
// Shared card/main RAM arbiter for the video scanner, CPU and disk DMA requesters.
// Video has top priority; CPU outranks disk until disk has waited STARVE_LIMIT CPU grants.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ACC_CYCLES   = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              mclk28,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dsk_req,
    input  logic              dsk_we,
    input  logic [ADDR_W-1:0] dsk_addr,
    input  logic [DATA_W-1:0] dsk_wdata,
    output logic              dsk_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_we_n,
    output logic              ram_oe_n,
    output logic [1:0]        gnt
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_VID  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_DSK  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACC_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  starve, starve_nxt;
    logic [1:0]        gnt_nxt;
    logic              vid_ack_nxt, cpu_ack_nxt, dsk_ack_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_dout_nxt;
    logic              ram_we_n_nxt, ram_oe_n_nxt;
    logic [1:0]        win_c;

    // State and registered outputs
    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            starve   <= '0;
            gnt      <= GNT_NONE;
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            dsk_ack  <= 1'b0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_dout <= '0;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            starve   <= starve_nxt;
            gnt      <= gnt_nxt;
            vid_ack  <= vid_ack_nxt;
            cpu_ack  <= cpu_ack_nxt;
            dsk_ack  <= dsk_ack_nxt;
            rdata    <= rdata_nxt;
            ram_addr <= ram_addr_nxt;
            ram_dout <= ram_dout_nxt;
            ram_we_n <= ram_we_n_nxt;
            ram_oe_n <= ram_oe_n_nxt;
        end
    end

    // Next-state, arbitration and output logic
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        starve_nxt   = starve;
        gnt_nxt      = gnt;
        vid_ack_nxt  = 1'b0;
        cpu_ack_nxt  = 1'b0;
        dsk_ack_nxt  = 1'b0;
        rdata_nxt    = rdata;
        ram_addr_nxt = ram_addr;
        ram_dout_nxt = ram_dout;
        ram_we_n_nxt = ram_we_n;
        ram_oe_n_nxt = ram_oe_n;
        win_c        = GNT_NONE;

        if (vid_req) begin
            win_c = GNT_VID;
        end else if (dsk_req && (starve == STARVE_MAX)) begin
            win_c = GNT_DSK;
        end else if (cpu_req) begin
            win_c = GNT_CPU;
        end else if (dsk_req) begin
            win_c = GNT_DSK;
        end

        case (state)
            ST_IDLE: begin
                gnt_nxt      = win_c;
                ram_we_n_nxt = 1'b1;
                ram_oe_n_nxt = 1'b1;
                case (win_c)
                    GNT_VID: begin
                        ram_addr_nxt = vid_addr;
                        ram_dout_nxt = '0;
                        ram_oe_n_nxt = 1'b0;
                    end
                    GNT_CPU: begin
                        ram_addr_nxt = cpu_addr;
                        ram_dout_nxt = cpu_wdata;
                        ram_we_n_nxt = !cpu_we;
                        ram_oe_n_nxt = cpu_we;
                    end
                    GNT_DSK: begin
                        ram_addr_nxt = dsk_addr;
                        ram_dout_nxt = dsk_wdata;
                        ram_we_n_nxt = !dsk_we;
                        ram_oe_n_nxt = dsk_we;
                    end
                    default: ;
                endcase
                if (win_c != GNT_NONE) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_ACCESS;
                end
                // Starvation tracks only CPU wins that actually held disk off
                if (!dsk_req || (win_c == GNT_DSK)) begin
                    starve_nxt = '0;
                end else if ((win_c == GNT_CPU) && (starve < STARVE_MAX)) begin
                    starve_nxt = starve + CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    if (!ram_oe_n) begin
                        rdata_nxt = ram_din;
                    end
                    ram_we_n_nxt = 1'b1;
                    ram_oe_n_nxt = 1'b1;
                    vid_ack_nxt  = (gnt == GNT_VID);
                    cpu_ack_nxt  = (gnt == GNT_CPU);
                    dsk_ack_nxt  = (gnt == GNT_DSK);
                    state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_nxt   = GNT_NONE;
                state_nxt = ST_IDLE;
            end
            default: begin
                gnt_nxt      = GNT_NONE;
                ram_we_n_nxt = 1'b1;
                ram_oe_n_nxt = 1'b1;
                state_nxt    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 18-bit card/main RAM between three requesters: video scanner (VID), CPU with the language-card/Saturn-mapped address (CPU), and the disk track-buffer DMA (DSK).
- Fixed priority with a disk anti-starvation override.
- Each access is sequenced as a fixed-length RAM cycle with req/ack handshakes.
- Sits between the address-mapping logic and the RAM primitive.

Parameters:
- ADDR_W, 18, RAM address width.
- DATA_W, 8, data width.
- ACC_CYCLES, 3, cycles the RAM strobes are held per access (legal range 1..15).
- STARVE_LIMIT, 4, consecutive CPU grants with DSK pending after which DSK outranks CPU (legal range 1..15).

Ports:
- mclk28  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request; read-only.
- vid_addr  in  ADDR_W  video address.
- vid_ack  out  1  one-cycle completion pulse.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  mapped CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  completion pulse.
- dsk_req, dsk_we, dsk_addr, dsk_wdata, dsk_ack  as CPU, for disk DMA.
- rdata  out  DATA_W  read data; valid while the selected ack is high.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  out  DATA_W  RAM write data.
- ram_din  in  DATA_W  RAM read data.
- ram_we_n  out  1  RAM write strobe, active low.
- ram_oe_n  out  1  RAM output enable, active low.
- gnt  out  2  current owner: 0 none, 1 VID, 2 CPU, 3 DSK.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; gnt=0; all acks 0.
  - ram_we_n=1, ram_oe_n=1; ram_addr, ram_dout, rdata = 0.
  - Starve counter 0.
  - An in-flight access is abandoned without an ack.
- FSM states IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - Samples requests and picks a winner.
  - Priority order: VID > CPU > DSK.
  - Exception: if starve==STARVE_LIMIT, the order is VID > DSK > CPU.
  - On a winner: latch its addr, we and wdata into ram_addr/ram_dout; set gnt; load cnt=ACC_CYCLES-1; go to ACCESS.
  - If the winner is a write, ram_we_n=0; if a read, ram_oe_n=0.
  - No request: stay in IDLE, gnt=0.
- ACCESS:
  - Strobes, address and data are held stable.
  - If cnt>0, decrement.
  - If cnt==0: capture ram_din into rdata (reads only; writes leave rdata unchanged), deassert both strobes, raise the winner's ack, go to DONE.
- DONE:
  - The ack is high for exactly this cycle.
  - The next edge returns to IDLE with the ack and gnt cleared.
- Handshake rules:
  - A requester holds req and its request fields stable from assertion until it sees its ack.
  - At the edge ending DONE it may drop req, or present a new request with req held high.
  - IDLE then arbitrates on those updated values. Back-to-back requests from the same requester are legal.
  - Timing: request sampled in IDLE at edge T. Strobes are active for ACC_CYCLES cycles starting at T+1. Ack is high in cycle T+ACC_CYCLES+1. Throughput is one access per ACC_CYCLES+2 cycles.
- Strobes:
  - ram_we_n and ram_oe_n are never both low.
  - Both are high in IDLE and DONE.
- Video writes: none exist; VID is always a read.
- Starve counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on each CPU grant made while dsk_req=1.
  - Clears on a DSK grant, and in any IDLE cycle with dsk_req=0.
  - VID grants leave it unchanged.
- Simultaneous events:
  - Requests that lose arbitration stay pending (req held); no ack is issued.
  - A request that rises during ACCESS or DONE waits for the next IDLE.
- Acks are mutually exclusive; at most one is high per cycle.

Test Plan:
- Single CPU read, ACC_CYCLES=3, RAM holds 0xA5 at 0x1D123; cpu_req raised, sampled at edge 0:
  - ram_oe_n low for cycles 1-3, ram_addr=0x1D123.
  - cpu_ack high in cycle 4 only, rdata=0xA5, gnt=2 during cycles 1-4.
- CPU write 0x3C to 0x0C000:
  - ram_we_n low exactly 3 cycles, ram_dout=0x3C, ram_oe_n stays 1.
  - A subsequent read returns 0x3C; rdata is unchanged by the write.
- VID, CPU and DSK all requesting in the same IDLE cycle, each dropping req after its ack:
  - Grant order VID, CPU, DSK.
  - Acks at cycles 4, 9 and 14 relative to the first sample.
- CPU requesting continuously back-to-back with DSK held high, STARVE_LIMIT=4, VID idle:
  - Four CPU grants, then a DSK grant, then CPU again; pattern repeats.
  - With dsk_req low, the counter stays 0.
- reset_n pulsed low during ACCESS of a CPU write:
  - Immediately ram_we_n=1, gnt=0, no ack.
  - After release, a pending request is granted fresh from IDLE.
- VID held continuously with CPU pending:
  - CPU is never granted while VID is held (VID has absolute priority).
  - Releasing VID grants CPU at the next IDLE.
